// File: rtl/capture_pkg.sv
// Shared types and defaults for the AD9284 capture-window sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  localparam int CAPTURE_LEN_DEF = 16384;
  localparam int HOLDOFF_DEF     = 16;

endpackage

// File: rtl/capture_strobe_gen.sv
// Decimation phase counter and window slot counter; predicts whether the
// next cycle is a sample slot so the top level can register dv directly.
module capture_strobe_gen
  import capture_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int CAPTURE_LEN = CAPTURE_LEN_DEF
) (
  input  logic             dclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_capture,
  input  logic [7:0]       decim,
  input  logic [CNT_W-1:0] len,
  output logic             slot_next,
  output logic             last_slot
);

  logic [7:0]       phase_q, phase_d;
  logic [7:0]       decim_q, decim_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             slot_now;

  // next-state of the counters; phase_q is the phase of the current cycle
  always_comb begin
    phase_d    = phase_q;
    decim_d    = decim_q;
    slot_cnt_d = slot_cnt_q;
    len_d      = len_q;
    slot_now   = (phase_q == 8'd0);
    last_slot  = in_capture && slot_now && (slot_cnt_q == len_q - CNT_W'(1));
    if (start) begin
      len_d      = (len == {CNT_W{1'b0}}) ? CNT_W'(CAPTURE_LEN) : len;
      decim_d    = decim;
      phase_d    = 8'd0;
      slot_cnt_d = {CNT_W{1'b0}};
    end else if (in_capture) begin
      if (slot_now) begin
        phase_d    = decim_q;
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
      end else begin
        phase_d    = phase_q - 8'd1;
      end
    end else begin
      phase_d = phase_q;
    end
    slot_next = (phase_d == 8'd0);
  end

  // counter registers
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      phase_q    <= 8'd0;
      decim_q    <= 8'd0;
      slot_cnt_q <= {CNT_W{1'b0}};
      len_q      <= CNT_W'(1);
    end else begin
      phase_q    <= phase_d;
      decim_q    <= decim_d;
      slot_cnt_q <= slot_cnt_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Capture-window controller: arm/trigger/holdoff FSM, per-channel dv gating
// against FIFO full, sticky overflow flags and completed-window counter.
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int CAPTURE_LEN = CAPTURE_LEN_DEF,
  parameter int HOLDOFF     = HOLDOFF_DEF,
  parameter int AUTO_ARM    = 1
) (
  input  logic              dclk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              stop,
  input  logic              cont,
  input  logic              trig_en,
  input  logic              trig_ext,
  input  logic [7:0]        decim,
  input  logic [CNT_W-1:0]  len,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] dv,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] overflow,
  output logic [15:0]       frame_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  cap_state_e        state_q, state_d;
  logic [NUM_CH-1:0] dv_q, dv_d, overflow_q, overflow_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              trig_prev_q, trig_prev_d, auto_arm_q, auto_arm_d;
  logic              start_s, in_capture_s, slot_next_s, last_slot_s, arm_eff_s;

  // trigger launch kept outside the FSM comb so slot prediction has no loop
  assign arm_eff_s    = arm | auto_arm_q;
  assign in_capture_s = (state_q == ST_CAPTURE);
  assign start_s      = (state_q == ST_ARMED) && (!trig_en || (trig_ext && !trig_prev_q)) && !stop;

  capture_strobe_gen #(
    .CNT_W       (CNT_W),
    .CAPTURE_LEN (CAPTURE_LEN)
  ) u_strobe (
    .dclk       (dclk),
    .rst_n      (rst_n),
    .start      (start_s),
    .in_capture (in_capture_s),
    .decim      (decim),
    .len        (len),
    .slot_next  (slot_next_s),
    .last_slot  (last_slot_s)
  );

  // FSM next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    trig_prev_d = trig_ext;
    auto_arm_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_eff_s) begin
          state_d    = ST_ARMED;
          overflow_d = {NUM_CH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (start_s) state_d = ST_CAPTURE;
        else         state_d = ST_ARMED;
      end
      ST_CAPTURE: begin
        if (last_slot_s) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          hold_cnt_d  = {CNT_W{1'b0}};
          if (!cont)             state_d = ST_DONE;
          else if (HOLDOFF == 0) state_d = ST_ARMED;
          else                   state_d = ST_HOLDOFF;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) state_d = ST_ARMED;
        else                         hold_cnt_d = hold_cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        if (arm) begin
          state_d    = ST_ARMED;
          overflow_d = {NUM_CH{1'b0}};
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // stop wins over everything and discards the current window
    if (stop) begin
      state_d     = ST_IDLE;
      frame_cnt_d = frame_cnt_q;
    end else begin
      frame_cnt_d = frame_cnt_d;
    end
    if ((state_d == ST_CAPTURE) && slot_next_s) begin
      dv_d       = ch_en & ~fifo_full;
      overflow_d = overflow_d | (ch_en & fifo_full);
    end else begin
      dv_d = {NUM_CH{1'b0}};
    end
    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE) || (state_d == ST_HOLDOFF);
    done_d = (state_d == ST_DONE);
  end

  // state and output registers
  always_ff @(posedge dclk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dv_q        <= {NUM_CH{1'b0}};
      overflow_q  <= {NUM_CH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      hold_cnt_q  <= {CNT_W{1'b0}};
      trig_prev_q <= trig_ext;
      auto_arm_q  <= (AUTO_ARM != 0);
    end else begin
      state_q     <= state_d;
      dv_q        <= dv_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      trig_prev_q <= trig_prev_d;
      auto_arm_q  <= auto_arm_d;
    end
  end

  assign dv        = dv_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;

endmodule
